junction_sequencer: RTL



---
 rtl/junction_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/junction_sequencer.sv
// Purpose : two-approach junction controller (road A main, road B side) with a latched
//           pedestrian phase; every handover of right-of-way passes through an all-red clearance.
// Latency : lamps decode combinationally from the state register; state changes one clk after its cause.
// Backpressure: none; requests are levels (a_req/b_req) or latched (ped_req), never dropped or stalled.
// Ports   : clk, rst_n (async active-low), enable (0 forces OFF), a_req, b_req, ped_req (any-width pulse);
//           a_/b_ red/amber/green lamps, walk, ped_ack (1-cycle pulse on walk grant), state_out[3:0].
module junction_sequencer #(
  parameter int TW          = 8,
  parameter int T_CLEAR     = 2,
  parameter int T_RDYLW     = 2,
  parameter int T_GREEN_MIN = 4,
  parameter int T_GREEN_MAX = 10,
  parameter int T_YELLOW    = 3,
  parameter int T_WALK      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       a_req,
  input  logic       b_req,
  input  logic       ped_req,
  output logic       a_red,
  output logic       a_amber,
  output logic       a_green,
  output logic       b_red,
  output logic       b_amber,
  output logic       b_green,
  output logic       walk,
  output logic       ped_ack,
  output logic [3:0] state_out
);

  if (T_CLEAR < 1 || T_RDYLW < 1 || T_GREEN_MIN < 1 || T_GREEN_MAX < 1 ||
      T_YELLOW < 1 || T_WALK < 1 || T_GREEN_MIN > T_GREEN_MAX ||
      T_GREEN_MAX >= (1 << TW)) begin : g_bad_params
    $error("junction_sequencer: illegal timing parameters");
  end

  typedef enum logic [3:0] {
    S_OFF      = 4'd0,
    S_ALL_RED  = 4'd1,
    S_A_RDYLW  = 4'd2,
    S_A_GREEN  = 4'd3,
    S_A_YELLOW = 4'd4,
    S_B_RDYLW  = 4'd5,
    S_B_GREEN  = 4'd6,
    S_B_YELLOW = 4'd7,
    S_PED_WALK = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    SRV_A   = 2'd0,
    SRV_B   = 2'd1,
    SRV_PED = 2'd2
  } srv_t;

  // Exit compares: a dwell of T cycles leaves when the timer reads T-1.
  localparam logic [TW-1:0] L_CLEAR = TW'(T_CLEAR - 1);
  localparam logic [TW-1:0] L_RDYLW = TW'(T_RDYLW - 1);
  localparam logic [TW-1:0] L_GMIN  = TW'(T_GREEN_MIN - 1);
  localparam logic [TW-1:0] L_GMAX  = TW'(T_GREEN_MAX - 1);
  localparam logic [TW-1:0] L_YLW   = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] L_WALK  = TW'(T_WALK - 1);

  state_t        r_state, w_next;
  srv_t          r_next_srv, w_next_srv;
  logic          r_last_b, w_last_b;   // 1 = road B was the last road served
  logic [TW-1:0] r_timer;
  logic          r_ped_pending;
  logic          r_ped_ack;
  logic          w_enter_walk;

  always_comb begin
    w_next     = r_state;
    w_next_srv = r_next_srv;
    w_last_b   = r_last_b;
    case (r_state)
      S_OFF: begin
        w_next     = S_ALL_RED;
        w_next_srv = SRV_A;
      end
      S_ALL_RED: if (r_timer == L_CLEAR) begin
        case (r_next_srv)
          SRV_B:   w_next = S_B_RDYLW;
          SRV_PED: w_next = S_PED_WALK;
          default: w_next = S_A_RDYLW;
        endcase
      end
      S_A_RDYLW: if (r_timer == L_RDYLW) w_next = S_A_GREEN;
      S_B_RDYLW: if (r_timer == L_RDYLW) w_next = S_B_GREEN;
      S_A_GREEN: if ((r_timer >= L_GMIN && (b_req || r_ped_pending)) || r_timer == L_GMAX)
        w_next = S_A_YELLOW;
      S_B_GREEN: if ((r_timer >= L_GMIN && (a_req || r_ped_pending)) || r_timer == L_GMAX)
        w_next = S_B_YELLOW;
      S_A_YELLOW: if (r_timer == L_YLW) begin
        w_next     = S_ALL_RED;
        w_next_srv = r_ped_pending ? SRV_PED : SRV_B;
        w_last_b   = 1'b0;
      end
      S_B_YELLOW: if (r_timer == L_YLW) begin
        w_next     = S_ALL_RED;
        w_next_srv = r_ped_pending ? SRV_PED : SRV_A;
        w_last_b   = 1'b1;
      end
      S_PED_WALK: if (r_timer == L_WALK) begin
        w_next     = S_ALL_RED;
        w_next_srv = r_last_b ? SRV_A : SRV_B;
      end
      default: w_next = S_OFF;
    endcase
    // enable has priority over every exit: straight to dark, no amber run-out.
    if (!enable) w_next = S_OFF;
  end

  assign w_enter_walk = (w_next == S_PED_WALK) && (r_state != S_PED_WALK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_OFF;
      r_next_srv    <= SRV_A;
      r_last_b      <= 1'b0;
      r_timer       <= '0;
      r_ped_pending <= 1'b0;
      r_ped_ack     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_next_srv <= w_next_srv;
      r_last_b   <= w_last_b;
      r_ped_ack  <= w_enter_walk;
      if (w_next != r_state || !enable) r_timer <= '0;
      else                              r_timer <= r_timer + 1'b1;
      // Clearing on walk entry wins over a same-cycle press: that press is served by this walk.
      if (!enable || r_state == S_OFF || w_enter_walk) r_ped_pending <= 1'b0;
      else if (ped_req && r_state != S_PED_WALK)       r_ped_pending <= 1'b1;
    end
  end

  always_comb begin
    a_red   = 1'b0;
    a_amber = 1'b0;
    a_green = 1'b0;
    b_red   = 1'b0;
    b_amber = 1'b0;
    b_green = 1'b0;
    walk    = 1'b0;
    case (r_state)
      S_ALL_RED:  begin a_red = 1'b1; b_red = 1'b1; end
      S_A_RDYLW:  begin a_red = 1'b1; a_amber = 1'b1; b_red = 1'b1; end
      S_A_GREEN:  begin a_green = 1'b1; b_red = 1'b1; end
      S_A_YELLOW: begin a_amber = 1'b1; b_red = 1'b1; end
      S_B_RDYLW:  begin b_red = 1'b1; b_amber = 1'b1; a_red = 1'b1; end
      S_B_GREEN:  begin b_green = 1'b1; a_red = 1'b1; end
      S_B_YELLOW: begin b_amber = 1'b1; a_red = 1'b1; end
      S_PED_WALK: begin a_red = 1'b1; b_red = 1'b1; walk = 1'b1; end
      default: ;
    endcase
  end

  assign ped_ack   = r_ped_ack;
  assign state_out = r_state;

endmodule
